// File: rtl/bcd_conv_arbiter.sv
// Round-robin scheduler that shares one binary-to-BCD converter among N_REQ requesters.
// It latches the operand, resets and launches the converter, then returns the tagged result.
module bcd_conv_arbiter #(
  parameter int N_REQ   = 4,
  parameter int IN_W    = 7,
  parameter int MAX_VAL = 99,
  parameter int TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*IN_W-1:0]   req_data,
  output logic [N_REQ-1:0]        gnt,
  output logic [7:0]              res_bcd,
  output logic [2:0]              res_id,
  output logic                    res_valid,
  output logic                    res_err,
  output logic                    conv_rst,
  output logic                    conv_init,
  output logic [IN_W-1:0]         conv_operand,
  input  logic                    conv_done,
  input  logic [7:0]              conv_bcd,
  output logic                    busy
);

  // state   | meaning
  // IDLE    | waiting for any request
  // GRANT   | operand latched; reject or reset converter
  // LAUNCH  | converter start pulse
  // WAIT    | waiting for conv_done or timeout
  // DELIVER | result, gnt and tag valid for one cycle
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_GRANT   = 3'd1;
  localparam logic [2:0] S_LAUNCH  = 3'd2;
  localparam logic [2:0] S_WAIT    = 3'd3;
  localparam logic [2:0] S_DELIVER = 3'd4;

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [2:0]       r_state;
  logic [2:0]       r_ptr;
  logic [2:0]       r_id;
  logic [IN_W-1:0]  r_operand;
  logic [7:0]       r_bcd;
  logic             r_err;
  logic [CNT_W-1:0] r_cnt;

  logic [2*N_REQ-1:0] w_dbl;
  logic               w_found;
  logic [2:0]         w_pick;
  int                 w_sum;
  logic [IN_W-1:0]    w_operand;
  logic               w_reject;
  logic               w_timeout;

  // Doubling the request vector lets a plain shift implement the wrap-around search.
  assign w_dbl = {req, req} >> r_ptr;

  always_comb begin
    w_found = 1'b0;
    w_pick  = 3'd0;
    w_sum   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!w_found && w_dbl[k]) begin
        w_found = 1'b1;
        w_sum   = int'(r_ptr) + k;
        if (w_sum >= N_REQ) w_sum = w_sum - N_REQ;
        w_pick  = 3'(w_sum);
      end
    end
  end

  always_comb begin
    w_operand = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_pick == 3'(i)) w_operand = req_data[i*IN_W +: IN_W];
    end
  end

  assign w_reject  = 32'(w_operand) > MAX_VAL;
  // A done arriving on the terminal-count cycle wins over the timeout.
  assign w_timeout = (r_state == S_WAIT) && !conv_done && (r_cnt == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_ptr     <= 3'd0;
      r_id      <= 3'd0;
      r_operand <= '0;
      r_bcd     <= 8'h00;
      r_err     <= 1'b0;
      r_cnt     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_id      <= w_pick;
            r_operand <= w_operand;
            r_err     <= w_reject;
            r_bcd     <= 8'h00;
            r_state   <= S_GRANT;
          end
        end
        S_GRANT:  r_state <= r_err ? S_DELIVER : S_LAUNCH;
        S_LAUNCH: begin
          r_cnt   <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (conv_done) begin
            r_bcd   <= conv_bcd;
            r_err   <= 1'b0;
            r_state <= S_DELIVER;
          end else if (r_cnt == CNT_LAST) begin
            r_bcd   <= 8'h00;
            r_err   <= 1'b1;
            r_state <= S_DELIVER;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DELIVER: begin
          r_ptr   <= (r_id == 3'(N_REQ - 1)) ? 3'd0 : r_id + 3'd1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign res_valid    = (r_state == S_DELIVER);
  assign gnt          = res_valid ? (N_REQ'(1) << r_id) : '0;
  assign res_id       = res_valid ? r_id : 3'd0;
  assign res_bcd      = res_valid ? r_bcd : 8'h00;
  assign res_err      = res_valid & r_err;
  assign conv_rst     = ((r_state == S_GRANT) && !r_err) || w_timeout;
  assign conv_init    = (r_state == S_LAUNCH);
  assign conv_operand = r_operand;
  assign busy         = (r_state != S_IDLE);

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Directed bench for bcd_conv_arbiter with a behavioural converter model.
// Expected results are hand-computed constants per scenario.
module tb_bcd_conv_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [27:0] req_data;
  logic [3:0]  gnt;
  logic [7:0]  res_bcd;
  logic [2:0]  res_id;
  logic        res_valid, res_err, conv_rst, conv_init, conv_done, busy;
  logic [6:0]  conv_operand;
  logic [7:0]  conv_bcd;

  int n_checks = 0;
  int n_fail   = 0;

  bcd_conv_arbiter #(.N_REQ(4), .IN_W(7), .MAX_VAL(99), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .gnt(gnt),
    .res_bcd(res_bcd), .res_id(res_id), .res_valid(res_valid), .res_err(res_err),
    .conv_rst(conv_rst), .conv_init(conv_init), .conv_operand(conv_operand),
    .conv_done(conv_done), .conv_bcd(conv_bcd), .busy(busy)
  );

  always #5 clk = ~clk;

  // Converter model: done rises conv_lat cycles after init loads; 0 means never.
  int         conv_lat = 0;
  logic       stale_en = 1'b0;
  logic       m_done   = 1'b0;
  logic [7:0] m_bcd    = 8'h00;
  int         m_cnt    = 0;

  assign conv_done = m_done | (stale_en & conv_init);
  assign conv_bcd  = m_bcd;

  always @(posedge clk) begin
    if (conv_rst) begin
      m_done <= 1'b0; m_bcd <= 8'h00; m_cnt <= 0;
    end else if (conv_init) begin
      m_done <= 1'b0; m_cnt <= conv_lat;
    end else if (m_cnt == 1) begin
      m_done <= 1'b1;
      m_bcd  <= {4'(conv_operand / 10), 4'(conv_operand % 10)};
      m_cnt  <= 0;
    end else if (m_cnt > 1) begin
      m_cnt <= m_cnt - 1;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [27:0] pack(input int a, input int b, input int c, input int d);
    return {7'(d), 7'(c), 7'(b), 7'(a)};
  endfunction

  logic       o_ok;
  logic [7:0] o_bcd;
  logic [2:0] o_id;
  logic       o_err;
  logic [3:0] o_gnt;
  int         o_cyc, o_nrst, o_ninit, o_crst, o_cinit;

  task automatic start(input logic [3:0] r, input logic [27:0] d);
    @(negedge clk);
    req = r;
    req_data = d;
  endtask

  task automatic run_wait(input int max_cyc, input logic drop);
    o_ok = 1'b0; o_bcd = 8'h00; o_id = 3'd0; o_err = 1'b0; o_gnt = 4'h0;
    o_cyc = 0; o_nrst = 0; o_ninit = 0; o_crst = 0; o_cinit = 0;
    while (!o_ok && o_cyc < max_cyc) begin
      @(negedge clk);
      o_cyc++;
      if (conv_rst)  begin o_nrst++;  o_crst  = o_cyc; end
      if (conv_init) begin o_ninit++; o_cinit = o_cyc; end
      if (res_valid) begin
        o_ok = 1'b1; o_bcd = res_bcd; o_id = res_id; o_err = res_err; o_gnt = gnt;
        if (drop) req = 4'h0;
      end
    end
  endtask

  logic [7:0] fair_bcd [5] = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h10};
  logic [2:0] fair_id  [5] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
  logic       seen_bad;
  int         guard;

  initial begin
    rst = 1'b1; req = 4'h0; req_data = '0;
    #1;
    check_val("reset_outputs",
              {28'(0), busy, res_valid, res_err, conv_rst} | {gnt, res_bcd, res_id, conv_init, conv_operand, 9'(0)},
              32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Fairness: all four held, pointer wraps after id 3
    conv_lat = 2;
    start(4'b1111, pack(10, 20, 30, 40));
    for (int i = 0; i < 5; i++) begin
      run_wait(50, i == 4);
      check_val($sformatf("fair%0d_done", i), 32'(o_ok), 32'd1);
      check_val($sformatf("fair%0d_id", i), 32'(o_id), 32'(fair_id[i]));
      check_val($sformatf("fair%0d_bcd", i), 32'(o_bcd), 32'(fair_bcd[i]));
      check_val($sformatf("fair%0d_gnt", i), 32'(o_gnt), 32'(4'b0001 << fair_id[i]));
    end

    // Single request, operand 47
    conv_lat = 20;
    start(4'b0001, pack(47, 0, 0, 0));
    run_wait(60, 1'b1);
    check_val("single_done", 32'(o_ok), 32'd1);
    check_val("single_bcd", 32'(o_bcd), 32'h47);
    check_val("single_id", 32'(o_id), 32'd0);
    check_val("single_gnt", 32'(o_gnt), 32'b0001);
    check_val("single_err", 32'(o_err), 32'd0);
    check_val("single_nrst", 32'(o_nrst), 32'd1);
    check_val("single_init_after_rst", 32'(o_cinit - o_crst), 32'd1);

    // Rejection: requester 2 with operand 100
    start(4'b0100, pack(0, 0, 100, 0));
    run_wait(20, 1'b1);
    check_val("rej_latency", 32'(o_cyc), 32'd2);
    check_val("rej_err", 32'(o_err), 32'd1);
    check_val("rej_bcd", 32'(o_bcd), 32'h00);
    check_val("rej_id", 32'(o_id), 32'd2);
    check_val("rej_conv_pulses", 32'(o_nrst + o_ninit), 32'd0);

    // Timeout: converter never finishes
    conv_lat = 0;
    start(4'b0010, pack(0, 55, 0, 0));
    run_wait(200, 1'b1);
    check_val("to_done", 32'(o_ok), 32'd1);
    check_val("to_err", 32'(o_err), 32'd1);
    check_val("to_bcd", 32'(o_bcd), 32'h00);
    check_val("to_nrst", 32'(o_nrst), 32'd2);
    check_val("to_rst_cycle", 32'(o_crst - o_cinit), 32'd64);
    check_val("to_valid_cycle", 32'(o_cyc - o_cinit), 32'd65);

    conv_lat = 3;
    start(4'b1000, pack(0, 0, 0, 5));
    run_wait(40, 1'b1);
    check_val("after_to_bcd", 32'(o_bcd), 32'h05);
    check_val("after_to_id", 32'(o_id), 32'd3);
    check_val("after_to_err", 32'(o_err), 32'd0);

    // Done arrives exactly on the terminal-count cycle
    conv_lat = 63;
    start(4'b0001, pack(63, 0, 0, 0));
    run_wait(120, 1'b1);
    check_val("tie_err", 32'(o_err), 32'd0);
    check_val("tie_bcd", 32'(o_bcd), 32'h63);
    check_val("tie_nrst", 32'(o_nrst), 32'd1);

    // Stale done during LAUNCH must be ignored
    conv_lat = 5;
    stale_en = 1'b1;
    start(4'b0010, pack(0, 12, 0, 0));
    run_wait(40, 1'b1);
    stale_en = 1'b0;
    check_val("stale_bcd", 32'(o_bcd), 32'h12);
    check_val("stale_err", 32'(o_err), 32'd0);

    // Asynchronous reset while in WAIT
    conv_lat = 30;
    start(4'b0001, pack(33, 0, 0, 0));
    guard = 0;
    while (!conv_init && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    check_val("rst_launch_seen", 32'(conv_init), 32'd1);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_outputs", {gnt, res_bcd, res_id, res_valid, res_err, conv_operand, conv_rst, conv_init, 6'(0)}, 32'h0);
    req = 4'h0;
    seen_bad = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (gnt != 4'h0 || res_valid) seen_bad = 1'b1;
    end
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (gnt != 4'h0 || res_valid) seen_bad = 1'b1;
    end
    check_val("rst_no_gnt", 32'(seen_bad), 32'd0);

    conv_lat = 4;
    start(4'b0100, pack(0, 0, 99, 0));
    run_wait(40, 1'b1);
    check_val("post_rst_bcd", 32'(o_bcd), 32'h99);
    check_val("post_rst_id", 32'(o_id), 32'd2);
    check_val("post_rst_nrst", 32'(o_nrst), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
